vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the vga_if pixel stream: generates hcount/vcount, sync and blanking that
//  every draw_* stage (draw_image and the object/overlay chains) consumes and forwards.
//  Sits at the head of the top_vga pipeline; its out port feeds the first draw stage.
//  Also emits a frame-start strobe and a frame counter for game-logic frame pacing.
// PARAMETERS
//  H_ACTIVE   1024  visible pixels per line
//  H_FP       24    horizontal front porch (pixels)
//  H_SYNC     136   hsync pulse width (pixels)
//  H_BP       160   horizontal back porch (pixels); H_TOTAL = sum = 1344
//  V_ACTIVE   768   visible lines per frame
//  V_FP       3     vertical front porch (lines)
//  V_SYNC     6     vsync pulse width (lines)
//  V_BP       29    vertical back porch (lines); V_TOTAL = sum = 806
//  HSYNC_POL  1'b0  asserted level of hsync (0 = negative polarity)
//  VSYNC_POL  1'b0  asserted level of vsync
// PORTS
//  clk          in   1     pixel clock (65 MHz for defaults)
//  rst_n        in   1     synchronous reset, active-low
//  en           in   1     1 = counters advance; 0 = freeze all outputs
//  out          out  vga_if.out  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
//  frame_start  out  1     one-cycle pulse when (hcount,vcount) becomes (0,0)
//  frame_cnt    out  16    completed-frame counter
// BEHAVIOUR
//  - Reset is synchronous and active-low: on rising clk with rst_n=0: hcount=0, vcount=0,
//    hblnk=0, vblnk=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, rgb=0, frame_start=0, frame_cnt=0.
//  - All outputs registered; sync/blank flags are computed from the NEXT counter values so
//    they are cycle-aligned with the hcount/vcount they describe (0 cycles skew between them).
//  - en=1: hcount increments each clk; at H_TOTAL-1 wraps to 0 and vcount increments;
//    vcount at V_TOTAL-1 with hcount wrap -> vcount=0.
//  - en=0: every output holds its value; frame_start forced 0. en re-asserted resumes.
//  - hblnk = (hcount >= H_ACTIVE); vblnk = (vcount >= V_ACTIVE).
//  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
//  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
//  - frame_start=1 for exactly the cycle where counters wrapped to (0,0); same cycle
//    frame_cnt increments (16-bit, wraps 0xFFFF -> 0x0000). Not asserted after reset itself.
//  - rst_n low mid-frame: next edge returns to reset state; first frame_start occurs after
//    one full frame (H_TOTAL*V_TOTAL cycles) of en=1.
//  - Counters width 11 bits; parameters must satisfy H_TOTAL, V_TOTAL <= 2048 (assert in sim).
// CONFIGURATION
//  VGA_TIMING_TEST_PATTERN_EN
//  - defined: rgb outside blanking = 8 vertical colour bars, bar index = hcount[9:7]:
//    {white 12'hFFF, yellow 12'hFF0, cyan 12'h0FF, green 12'h0F0, magenta 12'hF0F,
//    red 12'hF00, blue 12'h00F, black 12'h000}; rgb=0 in blanking. Registered, aligned.
//  - undefined: rgb constant 12'h000 (draw stages supply the background).
// TESTING
//  1. rst_n=0 two cycles, en=1 -> all outputs at reset values; release -> hcount=1 one cycle later.
//  2. en=1 run 1344 cycles -> hcount 1343 -> 0, vcount 0 -> 1; hblnk high exactly hcount 1024..1343.
//  3. Run one line -> hsync = 0 exactly for hcount 1048..1183 (136 cycles); vsync = 0 for vcount 771..776.
//  4. Run 2 frames (2*1344*806 cycles) -> frame_start pulses exactly twice, 1083264 cycles apart;
//     frame_cnt=2.
//  5. en=0 for 50 cycles at hcount=500 -> hcount stays 500, no frame_start; en=1 -> 501 next cycle.
//  6. With VGA_TIMING_TEST_PATTERN_EN: hcount=0,vcount=0 -> rgb=12'hFFF; hcount=130 -> 12'hFF0;
//     hcount=1030 -> 12'h000. Without the macro: rgb=0 at all points.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle passed from the timing generator through every draw stage.
// master drives the stream (timing source / stage output), slave consumes it.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (
      output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );

   modport slave (
      input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Head of the VGA pipeline: raster counters, sync/blank, frame strobe and frame counter.
// Optional colour-bar source on rgb when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int   H_ACTIVE  = 1024,
   parameter int   H_FP      = 24,
   parameter int   H_SYNC    = 136,
   parameter int   H_BP      = 160,
   parameter int   V_ACTIVE  = 768,
   parameter int   V_FP      = 3,
   parameter int   V_SYNC    = 6,
   parameter int   V_BP      = 29,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   vga_if.master       out,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 12-bit thresholds so a 2048-wide timing still compares correctly against 11-bit counters
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_param_chk
         $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
      end
   endgenerate

   logic        h_wrap;
   logic        v_wrap;
   logic        frame_wrap;
   logic [10:0] h_nxt;
   logic [10:0] v_nxt;
   logic        hblnk_nxt;
   logic        vblnk_nxt;
   logic        hsync_nxt;
   logic        vsync_nxt;
   logic [11:0] rgb_nxt;

   // Flags are derived from the next counter values so they land in the same cycle as the counts.
   always_comb begin
      h_wrap     = ({1'b0, out.hcount} == H_LAST);
      v_wrap     = ({1'b0, out.vcount} == V_LAST);
      frame_wrap = h_wrap && v_wrap;

      h_nxt = h_wrap ? 11'd0 : out.hcount + 11'd1;
      v_nxt = out.vcount;
      if (h_wrap) begin
         v_nxt = v_wrap ? 11'd0 : out.vcount + 11'd1;
      end

      hblnk_nxt = ({1'b0, h_nxt} >= H_ACT);
      vblnk_nxt = ({1'b0, v_nxt} >= V_ACT);
      hsync_nxt = (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_nxt = (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

      rgb_nxt = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (!hblnk_nxt && !vblnk_nxt) begin
         case (h_nxt[9:7])
            3'd0:    rgb_nxt = 12'hFFF;
            3'd1:    rgb_nxt = 12'hFF0;
            3'd2:    rgb_nxt = 12'h0FF;
            3'd3:    rgb_nxt = 12'h0F0;
            3'd4:    rgb_nxt = 12'hF0F;
            3'd5:    rgb_nxt = 12'hF00;
            3'd6:    rgb_nxt = 12'h00F;
            default: rgb_nxt = 12'h000;
         endcase
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out.hcount  <= 11'd0;
         out.vcount  <= 11'd0;
         out.hblnk   <= 1'b0;
         out.vblnk   <= 1'b0;
         out.hsync   <= ~HSYNC_POL;
         out.vsync   <= ~VSYNC_POL;
         out.rgb     <= 12'h000;
         frame_start <= 1'b0;
         frame_cnt   <= 16'd0;
      end else if (en) begin
         out.hcount  <= h_nxt;
         out.vcount  <= v_nxt;
         out.hblnk   <= hblnk_nxt;
         out.vblnk   <= vblnk_nxt;
         out.hsync   <= hsync_nxt;
         out.vsync   <= vsync_nxt;
         out.rgb     <= rgb_nxt;
         frame_start <= frame_wrap;
         if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end else begin
         // Frozen: everything holds except the strobe, which must not repeat.
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, shortened vertical timing so whole
// frames fit in a short run; reference model derives everything from an elapsed-cycle count.
module tb_vga_timing_gen;
   localparam int   HA = 1024, HF = 24, HS = 136, HB = 160;
   localparam int   VA = 8, VF = 1, VS = 2, VB = 2;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   FRAME = HT * VT;
   localparam logic HP = 1'b0, VP = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        frame_start;
   logic [15:0] frame_cnt;
   vga_if       vif ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .out         (vif),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   // model: n = enabled cycles since reset; fs_m = strobe expected this cycle
   longint      n;
   logic        fs_m;
   int          vectors;
   int          errors;
   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         n    = 0;
         fs_m = 1'b0;
      end else if (en) begin
         n    = n + 1;
         fs_m = (n % FRAME == 0);
      end else begin
         fs_m = 1'b0;
      end
      #1;
   endtask

   function automatic logic [54:0] exp_vec();
      int          h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
      logic [15:0] fc;
      h   = int'(n % HT);
      v   = int'((n / HT) % VT);
      hb  = (h >= HA);
      vb  = (v >= VA);
      hs  = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
      vs  = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
      rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (n != 0 && !hb && !vb) rgb = bars[(h >> 7) & 7];
`endif
      fc  = 16'((n / FRAME) & 64'hFFFF);
      return {11'(h), 11'(v), hs, vs, hb, vb, rgb, fs_m, fc};
   endfunction

   function automatic logic [54:0] obs_vec();
      return {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk,
              vif.rgb, frame_start, frame_cnt};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
         end
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if (vif.hcount !== 11'd1) begin
         errors++;
         $display("FAIL reset_release_hcount: got %0d want 1", vif.hcount);
      end
   endtask

   task automatic test_line();
      int hb_cnt = 0, hs_cnt = 0;
      en = 1'b1;
      for (int i = 0; i < HT; i++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (errors < 20) $display("FAIL line_vec n=%0d: got %h want %h", n, obs_vec(), exp_vec());
         end
         if (vif.hblnk) hb_cnt++;
         if (vif.hsync == HP) hs_cnt++;
      end
      vectors++;
      if (hb_cnt != HT - HA) begin
         errors++;
         $display("FAIL hblnk_width: got %0d want %0d", hb_cnt, HT - HA);
      end
      vectors++;
      if (hs_cnt != HS) begin
         errors++;
         $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS);
      end
   endtask

   task automatic test_en_freeze();
      int guard = 0;
      en = 1'b1;
      while (n % HT != 500 && guard < 2 * HT) begin
         tick();
         guard++;
      end
      en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec() || vif.hcount !== 11'd500) begin
            errors++;
            if (errors < 20) $display("FAIL freeze_hold: got %h want %h", obs_vec(), exp_vec());
         end
      end
      en = 1'b1;
      tick();
      vectors++;
      if (vif.hcount !== 11'd501 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL freeze_resume: got hcount %0d want 501", vif.hcount);
      end
   endtask

   task automatic test_random_en();
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (errors < 20) $display("FAIL random_en n=%0d: got %h want %h", n, obs_vec(), exp_vec());
         end
      end
      en = 1'b1;
   endtask

   task automatic test_frames();
      int     pulses = 0;
      longint first = -1, second = -1;
      rst_n = 1'b0;
      en    = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 2 * FRAME; i++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (errors < 20) $display("FAIL frame_vec n=%0d: got %h want %h", n, obs_vec(), exp_vec());
         end
         if (frame_start === 1'b1) begin
            pulses++;
            if (first < 0) first = i; else if (second < 0) second = i;
         end
      end
      vectors++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL frame_pulses: got %0d want 2", pulses);
      end
      vectors++;
      if (second - first != FRAME) begin
         errors++;
         $display("FAIL frame_spacing: got %0d want %0d", second - first, FRAME);
      end
      vectors++;
      if (frame_cnt !== 16'd2) begin
         errors++;
         $display("FAIL frame_cnt: got %0d want 2", frame_cnt);
      end
   endtask

   task automatic test_midframe_reset();
      int run = $urandom_range(1, 3000);
      en = 1'b1;
      for (int i = 0; i < run; i++) tick();
      rst_n = 1'b0;
      tick();
      vectors++;
      if (obs_vec() !== exp_vec() || vif.hcount !== 11'd0 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midframe_reset: got %h want %h", obs_vec(), exp_vec());
      end
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (errors < 20) $display("FAIL after_reset n=%0d: got %h want %h", n, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      n       = 0;
      fs_m    = 1'b0;
      rst_n   = 1'b0;
      en      = 1'b0;
      test_reset();
      test_line();
      test_en_freeze();
      test_random_en();
      test_frames();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
